// File: rtl/core_pkg.sv
// Shared types and constants for the core's memory-side blocks.
// Holds the arbiter state encoding and the LSU access-size codes.
package core_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} arb_state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  function automatic logic len_legal(input logic [1:0] len);
    return (len == LEN_BYTE) || (len == LEN_HALF) || (len == LEN_WORD);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between IFU, LSU, the data-memory slave and the arbiter.
// slave = arbiter view, master = the surrounding masters and memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              ifu_req_valid, ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [1:0]        lsu_len;
  logic              lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid, mem_req_ready, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_len;
  logic              mem_resp_valid, mem_resp_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_len, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_len, mem_resp_ready
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_len, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_len, mem_resp_ready
  );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one
// that was not served last. win = 0 selects requester 0.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       win
);
  assign win = (&valid) ? ~last : valid[1];
endmodule

// File: rtl/mem_arbiter.sv
// Shares the data-memory slave between IFU (read-only) and LSU with
// round-robin grants, one transaction in flight and a stall watchdog.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int             WDW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  arb_state_t     state, state_n;
  logic           grant, grant_n, last, last_n, win;
  logic [WDW-1:0] wdog, wdog_n;

  logic [1:0] req_v, req_rdy, rsp_vld, rsp_err;
  logic       rdata_en, mem_req_vld, mem_rsp_rdy, g_rsp_rdy;
  logic [ADDR_W-1:0] addr_mux;

  assign req_v     = {bus.lsu_req_valid, bus.ifu_req_valid};
  assign g_rsp_rdy = grant ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  rr_pick2 u_pick (.valid(req_v), .last(last), .win(win));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      wdog  <= wdog_n;
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    last_n      = last;
    wdog_n      = wdog;
    req_rdy     = '0;
    rsp_vld     = '0;
    rsp_err     = '0;
    rdata_en    = 1'b0;
    mem_req_vld = 1'b0;
    mem_rsp_rdy = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req_v) begin
          grant_n = win;
          state_n = S_REQ;
          wdog_n  = '0;
        end
      end
      S_REQ: begin
        mem_req_vld    = 1'b1;
        req_rdy[grant] = bus.mem_req_ready;
        if (bus.mem_req_ready) begin
          state_n = S_RESP;
          wdog_n  = '0;
        end else if (wdog == WD_LAST) begin
          state_n = S_ERR;
        end else begin
          wdog_n = wdog + WD_ONE;
        end
      end
      S_RESP: begin
        mem_rsp_rdy    = g_rsp_rdy;
        rsp_vld[grant] = bus.mem_resp_valid;
        rdata_en       = 1'b1;
        if (bus.mem_resp_valid && g_rsp_rdy) begin
          state_n = S_IDLE;
          last_n  = grant;
        end else if (wdog == WD_LAST) begin
          state_n = S_ERR;
        end else begin
          wdog_n = wdog + WD_ONE;
        end
      end
      S_ERR: begin
        // Synthesised error response; the slave is fenced off until IDLE.
        rsp_vld[grant] = 1'b1;
        rsp_err[grant] = 1'b1;
        if (g_rsp_rdy) begin
          state_n = S_IDLE;
          last_n  = grant;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign addr_mux = grant ? bus.lsu_addr : bus.ifu_addr;

  assign bus.mem_req_valid  = mem_req_vld;
  assign bus.mem_resp_ready = mem_rsp_rdy;
  assign bus.mem_addr       = addr_mux;
  assign bus.mem_wen        = grant & bus.lsu_wen;
  assign bus.mem_wdata      = grant ? bus.lsu_wdata : {DATA_W{1'b0}};
  assign bus.mem_len        = grant ? bus.lsu_len : LEN_WORD;

  assign bus.ifu_req_ready  = req_rdy[0];
  assign bus.lsu_req_ready  = req_rdy[1];
  assign bus.ifu_resp_valid = rsp_vld[0];
  assign bus.lsu_resp_valid = rsp_vld[1];
  assign bus.ifu_resp_err   = rsp_err[0];
  assign bus.lsu_resp_err   = rsp_err[1];
  assign bus.ifu_rdata      = (rdata_en && !grant) ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.lsu_rdata      = (rdata_en &&  grant) ? bus.mem_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed check of mem_arbiter against a transaction-level
// model: who owns the slave, which phase it is in, and how long it has waited.
module tb_mem_arbiter;
  import core_pkg::*;
  localparam int AW = 32, DW = 32, TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: phase 0 none, 1 request offered, 2 awaiting data, 3 error reply.
  int m_phase = 0, m_owner = 0, m_last = 1, m_wait = 0;

  function automatic bit rr(input int o);
    return (o == 1) ? bus.lsu_resp_ready : bus.ifu_resp_ready;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_owner <= 0; m_last <= 1; m_wait <= 0;
    end else begin
      case (m_phase)
        0: if (bus.ifu_req_valid || bus.lsu_req_valid) begin
             m_owner <= (bus.ifu_req_valid && bus.lsu_req_valid) ? 1 - m_last
                                                                 : (bus.lsu_req_valid ? 1 : 0);
             m_phase <= 1; m_wait <= 0;
           end
        1: if (bus.mem_req_ready) begin
             m_phase <= 2; m_wait <= 0;
           end else begin
             m_wait <= m_wait + 1;
             if (m_wait + 1 == TO) m_phase <= 3;
           end
        2: if (bus.mem_resp_valid && rr(m_owner)) begin
             m_phase <= 0; m_last <= m_owner;
           end else begin
             m_wait <= m_wait + 1;
             if (m_wait + 1 == TO) m_phase <= 3;
           end
        default: if (rr(m_owner)) begin
             m_phase <= 0; m_last <= m_owner;
           end
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic ow, e_mrv, e_mrr, e_iv, e_lv, e_ie, e_le;
    logic [DW-1:0] e_ird, e_lrd;
    ow    = (m_owner == 1);
    e_mrv = (m_phase == 1);
    e_mrr = (m_phase == 2) && rr(m_owner);
    e_iv  = !ow && ((m_phase == 2 && bus.mem_resp_valid) || m_phase == 3);
    e_lv  =  ow && ((m_phase == 2 && bus.mem_resp_valid) || m_phase == 3);
    e_ie  = !ow && m_phase == 3;
    e_le  =  ow && m_phase == 3;
    e_ird = (m_phase == 2 && !ow) ? bus.mem_rdata : '0;
    e_lrd = (m_phase == 2 &&  ow) ? bus.mem_rdata : '0;
    chk("ctrl",
        {bus.mem_req_valid, bus.mem_resp_ready, bus.ifu_req_ready, bus.lsu_req_ready,
         bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err},
        {e_mrv, e_mrr, e_mrv && !ow && bus.mem_req_ready, e_mrv && ow && bus.mem_req_ready,
         e_iv, e_lv, e_ie, e_le});
    chk("rdata", {bus.ifu_rdata, bus.lsu_rdata}, {e_ird, e_lrd});
    if (e_mrv)
      chk("mem_fields",
          {bus.mem_addr, bus.mem_wen, bus.mem_len, ow ? bus.mem_wdata : 32'h0},
          {ow ? bus.lsu_addr : bus.ifu_addr, ow && bus.lsu_wen,
           ow ? bus.lsu_len : LEN_WORD, ow ? bus.lsu_wdata : 32'h0});
  end

  logic ifu_hs = 1'b0, lsu_hs = 1'b0;

  task automatic to_neg();
    @(negedge clk);
    ifu_hs = bus.ifu_req_valid && bus.ifu_req_ready;
    lsu_hs = bus.lsu_req_valid && bus.lsu_req_ready;
  endtask
  task automatic to_pos(); @(posedge clk); #1; endtask
  task automatic tick(); to_neg(); to_pos(); endtask

  task automatic idle_inputs();
    bus.ifu_req_valid = 0; bus.ifu_addr = '0; bus.ifu_resp_ready = 0;
    bus.lsu_req_valid = 0; bus.lsu_addr = '0; bus.lsu_wen = 0; bus.lsu_wdata = '0;
    bus.lsu_len = LEN_WORD; bus.lsu_resp_ready = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    to_neg();
    chk("reset_outs", {bus.mem_req_valid, bus.mem_resp_ready, bus.ifu_req_ready, bus.lsu_req_ready,
                       bus.ifu_resp_valid, bus.lsu_resp_valid}, 6'b0);
    to_pos();
    rst = 1;
  endtask

  initial begin : global_bound
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected end before 1ms");
    $fatal(1, "bound expired");
  end

  initial begin
    int q[$];
    int found;
    #1;
    do_reset();

    // Single IFU read
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000; bus.mem_req_ready = 1; bus.ifu_resp_ready = 1;
    to_neg(); chk("ifu_lat_idle", bus.mem_req_valid, 1'b0); to_pos();
    to_neg();
    chk("ifu_req", {bus.mem_req_valid, bus.ifu_req_ready, bus.mem_wen, bus.mem_len, bus.mem_addr},
        {1'b1, 1'b1, 1'b0, 2'd2, 32'h8000_0000});
    to_pos();
    bus.ifu_req_valid = 0;
    tick();
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0000_0413;
    to_neg();
    chk("ifu_resp", {bus.ifu_resp_valid, bus.ifu_resp_err, bus.ifu_rdata,
                     bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_req_ready},
        {1'b1, 1'b0, 32'h413, 1'b0, 32'h0, 1'b0});
    to_pos();
    idle_inputs(); tick();

    // Simultaneous requests after reset
    do_reset();
    bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.ifu_addr = 32'h100; bus.lsu_addr = 32'h200;
    bus.mem_req_ready = 1; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h55;
    bus.ifu_resp_ready = 1; bus.lsu_resp_ready = 1;
    for (int i = 0; i < 20 && q.size() < 4; i++) begin
      tick();
      if (ifu_hs) q.push_back(0);
      if (lsu_hs) q.push_back(1);
    end
    if (q.size() == 4) chk("rr_order", {q[0][0], q[1][0], q[2][0], q[3][0]}, 4'b0101);
    else chk("rr_order_count", q.size(), 4);
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
    tick(); idle_inputs(); tick();

    // LSU store held off by the slave for 3 cycles
    bus.lsu_req_valid = 1; bus.lsu_wen = 1; bus.lsu_addr = 32'h8000_1000;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_len = LEN_BYTE; bus.lsu_resp_ready = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("st_hold", {bus.mem_req_valid, bus.lsu_req_ready, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_len},
          {1'b1, 1'b0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 2'd0});
      to_pos();
    end
    bus.mem_req_ready = 1;
    to_neg(); chk("st_accept", {bus.mem_req_valid, bus.lsu_req_ready, bus.mem_len}, {1'b1, 1'b1, 2'd0}); to_pos();
    bus.lsu_req_valid = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 1;
    tick(); idle_inputs(); tick();

    // Timeout: slave accepts the load but never answers
    bus.lsu_req_valid = 1; bus.lsu_wen = 0; bus.lsu_addr = 32'h40; bus.lsu_len = LEN_WORD;
    bus.mem_req_ready = 1; bus.mem_rdata = 32'hA5A5_A5A5;
    tick();
    to_neg(); chk("to_accept", bus.lsu_req_ready, 1'b1); to_pos();
    bus.lsu_req_valid = 0; bus.mem_req_ready = 0;
    found = -1;
    for (int n = 0; n < 10; n++) begin
      to_neg();
      if (bus.lsu_resp_err) begin found = n; break; end
      to_pos();
    end
    chk("timeout_cycles", found, 4);
    chk("timeout_resp", {bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_rdata, bus.mem_req_valid, bus.mem_resp_ready},
        {1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
    to_pos();
    bus.mem_resp_valid = 1;
    to_neg(); chk("late_resp_err", {bus.lsu_resp_valid, bus.mem_resp_ready}, 2'b10); to_pos();
    bus.lsu_resp_ready = 1;
    tick();
    to_neg(); chk("timeout_idle", {bus.lsu_resp_valid, bus.mem_req_valid, bus.mem_resp_ready}, 3'b0); to_pos();
    idle_inputs(); tick();

    // Back-pressure from the IFU on the response
    bus.ifu_req_valid = 1; bus.ifu_addr = 32'h300; bus.mem_req_ready = 1;
    tick(); tick();
    bus.ifu_req_valid = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      to_neg(); chk("bp_stall", {bus.mem_resp_ready, bus.ifu_resp_valid, bus.ifu_rdata}, {1'b0, 1'b1, 32'h1234}); to_pos();
    end
    bus.ifu_resp_ready = 1;
    to_neg(); chk("bp_done", {bus.mem_resp_ready, bus.ifu_resp_valid}, 2'b11); to_pos();
    idle_inputs();
    to_neg(); chk("bp_idle", {bus.ifu_resp_valid, bus.mem_req_valid}, 2'b0); to_pos();

    // Async reset in the middle of an LSU response, after an IFU grant
    bus.ifu_req_valid = 1; bus.mem_req_ready = 1; bus.mem_resp_valid = 1; bus.ifu_resp_ready = 1;
    tick(); tick();
    bus.ifu_req_valid = 0;
    tick(); idle_inputs();
    bus.lsu_req_valid = 1; bus.mem_req_ready = 1; bus.lsu_resp_ready = 1;
    tick(); tick();
    bus.lsu_req_valid = 0; bus.mem_resp_valid = 1;
    #1 chk("pre_reset", {bus.mem_resp_ready, bus.lsu_resp_valid}, 2'b11);
    #1 rst = 0;
    #1 chk("async_reset", {bus.mem_req_valid, bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid}, 4'b0);
    idle_inputs();
    to_pos(); tick();
    rst = 1;
    bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.mem_req_ready = 1;
    tick();
    to_neg(); chk("post_reset_tie", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10); to_pos();
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0; bus.mem_resp_valid = 1; bus.ifu_resp_ready = 1;
    tick(); idle_inputs(); tick();

    // Randomised traffic; masters hold their fields until accepted
    for (int c = 0; c < 3000; c++) begin
      if (!bus.ifu_req_valid || ifu_hs) begin
        bus.ifu_req_valid = ($urandom_range(0, 2) != 0);
        bus.ifu_addr      = $urandom;
      end
      if (!bus.lsu_req_valid || lsu_hs) begin
        bus.lsu_req_valid = ($urandom_range(0, 2) != 0);
        bus.lsu_addr      = $urandom;
        bus.lsu_wen       = $urandom_range(0, 1);
        bus.lsu_wdata     = $urandom;
        bus.lsu_len       = 2'($urandom_range(0, 2));
      end
      bus.ifu_resp_ready = ($urandom_range(0, 9) < 7);
      bus.lsu_resp_ready = ($urandom_range(0, 9) < 7);
      bus.mem_req_ready  = $urandom_range(0, 1);
      bus.mem_resp_valid = ($urandom_range(0, 9) < 4);
      bus.mem_rdata      = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
